// File: rtl/seq_signed_divider.sv
// Iterative radix-2 signed divider: restoring division on magnitudes,
// one quotient bit per clock, quotient truncated toward zero.
module seq_signed_divider #(
    parameter int pN = 4,
    localparam int N = 2 ** pN
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         En,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic         Busy,
    output logic         Valid,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         DivByZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  qreg_q, qreg_d;
    logic [N:0]    rem_q, rem_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [pN-1:0] cnt_q, cnt_d;
    logic          quo_neg_q, quo_neg_d;
    logic          rem_neg_q, rem_neg_d;
    logic          zero_q, zero_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;
    logic          valid_q, valid_d;
    logic [N+1:0]  trial;

    // Register update with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            qreg_q      <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            qreg_q      <= qreg_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            valid_q     <= valid_d;
        end
    end

    // Next-state, datapath step and result fix-up
    always_comb begin
        state_d     = state_q;
        qreg_d      = qreg_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        valid_d     = 1'b0;
        // Extra top bit makes the trial sign unambiguous
        trial = {rem_q, qreg_q[N-1]} - {2'b00, dvs_q};
        unique case (state_q)
            IDLE: begin
                if (En) begin
                    qreg_d    = Dividend[N-1] ? -Dividend : Dividend;
                    dvs_d     = Divisor[N-1] ? -Divisor : Divisor;
                    quo_neg_d = Dividend[N-1] ^ Divisor[N-1];
                    rem_neg_d = Dividend[N-1];
                    zero_d    = (Divisor == '0);
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                qreg_d = {qreg_q[N-2:0], ~trial[N+1]};
                rem_d  = trial[N+1] ? {rem_q[N-1:0], qreg_q[N-1]}
                                    : trial[N:0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == pN'(N - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // With a zero divisor R ends as |Dividend|, so the
                // signed remainder already equals Dividend.
                if (zero_q) begin
                    quotient_d = '1;
                end else begin
                    quotient_d = quo_neg_q ? -qreg_q : qreg_q;
                end
                remainder_d = rem_neg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
                dbz_d       = zero_q;
                valid_d     = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Busy      = (state_q != IDLE);
    assign Valid     = valid_q;
    assign Quotient  = quotient_q;
    assign Remainder = remainder_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed and random checks for seq_signed_divider (pN=4).
// Expected values are hand-computed or from native int division.
module tb_seq_signed_divider;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        En = 1'b0;
    logic [15:0] Dividend = '0;
    logic [15:0] Divisor = '0;
    logic        Busy;
    logic        Valid;
    logic [15:0] Quotient;
    logic [15:0] Remainder;
    logic        DivByZero;

    int n_vec = 0;
    int n_bad = 0;
    bit inject = 0;

    seq_signed_divider #(.pN(4)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .En        (En),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Valid     (Valid),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge; En is sampled on the following posedge
    task automatic start(input logic [15:0] a, input logic [15:0] b);
        En = 1'b1;
        Dividend = a;
        Divisor = b;
        @(negedge Clk);
        En = 1'b0;
    endtask

    // Returns at the negedge of the Valid cycle
    task automatic wait_res(input string tag, input logic [15:0] eq,
                            input logic [15:0] er, input logic ez);
        int n;
        int bc;
        n = 0;
        bc = int'(Busy);
        while (n < 40) begin
            @(negedge Clk);
            n++;
            if (inject && n == 4) begin
                En = 1'b1;
                Dividend = 16'd5;
                Divisor = 16'd9;
            end else if (inject && n == 5) begin
                En = 1'b0;
            end
            if (Valid) break;
            bc += int'(Busy);
        end
        if (!Valid) begin
            check({tag, " timeout"}, 32'(n), 32'd17);
        end else begin
            check({tag, " latency"}, 32'(n), 32'd17);
            check({tag, " busy_cycles"}, 32'(bc), 32'd17);
            check({tag, " busy_in_valid"}, 32'(Busy), 32'd0);
            check({tag, " Q"}, 32'(Quotient), 32'(eq));
            check({tag, " R"}, 32'(Remainder), 32'(er));
            check({tag, " DBZ"}, 32'(DivByZero), 32'(ez));
        end
    endtask

    task automatic go(input string tag, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] eq,
                      input logic [15:0] er, input logic ez);
        start(a, b);
        wait_res(tag, eq, er, ez);
    endtask

    initial begin
        int sa;
        int sb;
        int rq;
        int rr;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] prod;
        int vseen;

        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("rst Busy", 32'(Busy), 32'd0);
        check("rst Valid", 32'(Valid), 32'd0);
        check("rst Q", 32'(Quotient), 32'd0);
        check("rst R", 32'(Remainder), 32'd0);
        check("rst DBZ", 32'(DivByZero), 32'd0);

        go("100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        @(negedge Clk);
        check("valid_pulse", 32'(Valid), 32'd0);
        check("hold Q", 32'(Quotient), 32'd14);
        check("hold R", 32'(Remainder), 32'd2);

        go("-100/7", -16'sd100, 16'd7, -16'sd14, -16'sd2, 1'b0);
        go("100/-7", 16'd100, -16'sd7, -16'sd14, 16'd2, 1'b0);
        go("-100/-7", -16'sd100, -16'sd7, 16'd14, -16'sd2, 1'b0);
        go("5/9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0);
        go("min/-1", 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0);
        go("min/1", 16'h8000, 16'd1, 16'h8000, 16'd0, 1'b0);
        go("max/min", 16'h7FFF, 16'h8000, 16'd0, 16'h7FFF, 1'b0);
        go("1234/0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1);
        go("6/3", 16'd6, 16'd3, 16'd2, 16'd0, 1'b0);
        go("-7/0", -16'sd7, 16'd0, 16'hFFFF, -16'sd7, 1'b1);

        inject = 1;
        go("busy_ignore", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        inject = 0;

        // Next issue lands in the Valid cycle of the previous one
        start(16'd45, 16'd6);
        wait_res("b2b_a", 16'd7, 16'd3, 1'b0);
        start(-16'sd45, 16'd6);
        wait_res("b2b_b", -16'sd7, -16'sd3, 1'b0);

        start(16'd100, 16'd7);
        repeat (7) @(negedge Clk);
        Rst_n = 1'b0;
        En = 1'b1;
        Dividend = 16'd9;
        Divisor = 16'd3;
        @(negedge Clk);
        Rst_n = 1'b1;
        En = 1'b0;
        check("abort Busy", 32'(Busy), 32'd0);
        check("abort Valid", 32'(Valid), 32'd0);
        check("abort Q", 32'(Quotient), 32'd0);
        check("abort R", 32'(Remainder), 32'd0);
        check("abort DBZ", 32'(DivByZero), 32'd0);
        vseen = 0;
        repeat (20) begin
            @(negedge Clk);
            vseen += int'(Valid) + int'(Busy);
        end
        check("abort quiet", 32'(vseen), 32'd0);
        go("50/5", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            if (i % 2 == 0) begin
                b = 16'($urandom_range(1, 40));
                if ($urandom_range(0, 1) == 1) b = -b;
            end else begin
                b = 16'($urandom);
            end
            if (i == 5) a = 16'h8000;
            if (i == 7) b = 16'h8000;
            if (b == 16'd0) b = 16'd3;
            sa = int'($signed(a));
            sb = int'($signed(b));
            rq = sa / sb;
            rr = sa % sb;
            go("rand", a, b, 16'(rq), 16'(rr), 1'b0);
            prod = Quotient * b + Remainder;
            check("rand identity", 32'(prod), 32'(a));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
